// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioning path.
package btn_pkg;

    // Debounce/hold FSM states; 3-bit encoding shared with any consumer that decodes state.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        LONG       = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    // Default timings for a 100 MHz system clock.
    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int LONG_1S       = 100_000_000;
    localparam int REPEAT_200MS  = 20_000_000;

    // Counter width for a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic stable_q;
    logic stable_d;

    // Next-state of the chain: shift the raw level one stage per clock.
    always_comb begin
        meta_d   = d;
        stable_d = meta_q;
    end

    // Synchroniser flops; cleared asynchronously so the chain never holds a stale level out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            stable_q <= stable_d;
        end
    end

    assign q = stable_q;

endmodule

// File: rtl/btn_press_conditioner.sv
// Turns the raw push-button into a debounced level plus single-cycle press,
// release, long-press and auto-repeat pulses, and counts accepted presses.
module btn_press_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int REPEAT_CYCLES   = REPEAT_200MS,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             enable,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES);

    // Terminal values: every counter stops on an exact match, never a >= compare.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic btn_s;

    state_t            state_q,   state_d;
    state_t            ret_q,     ret_d;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              level_q,   level_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic              long_q,    long_d;
    logic              repeat_q,  repeat_d;

    // The FSM only ever sees the clk-domain copy of the button.
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // Next-state, counter and output decode; a low enable overrides every transition.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        count_d    = count_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            ret_d      = HELD;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            count_d    = '0;
            level_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    level_d = 1'b0;
                    if (btn_s) begin
                        state_d  = PRESS_DB;
                        db_cnt_d = '0;
                    end
                end

                PRESS_DB: begin
                    if (!btn_s) begin
                        // Button dropped before the debounce window closed: a glitch.
                        state_d = IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d    = HELD;
                        press_d    = 1'b1;
                        level_d    = 1'b1;
                        hold_cnt_d = '0;
                        count_d    = count_q + CNT_W'(1);
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end

                HELD: begin
                    // A release on the hold terminal edge wins; long_press is not raised.
                    if (!btn_s) begin
                        state_d  = RELEASE_DB;
                        db_cnt_d = '0;
                        ret_d    = HELD;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d   = LONG;
                        long_d    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end

                LONG: begin
                    if (!btn_s) begin
                        state_d  = RELEASE_DB;
                        db_cnt_d = '0;
                        ret_d    = LONG;
                    end else if (rep_cnt_q == REP_LAST) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end

                RELEASE_DB: begin
                    // Hold/repeat counters are left alone so a bounce resumes where it stopped.
                    level_d = 1'b1;
                    if (btn_s) begin
                        state_d = ret_q;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ret_q      <= HELD;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            count_q    <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            count_q    <= count_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign press_count   = count_q;

endmodule
